// File: rtl/vid_frame_tracker_pkg.sv
// Shared types and default geometry for the video frame tracker.
// The defaults describe a 1280x720 active raster.
package vid_frame_tracker_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_CNT_W    = 16;

endpackage : vid_frame_tracker_pkg

// File: rtl/vid_frame_tracker.sv
// Passive AXI4-Stream video tap: tracks pixel/line position, pulses frame completion
// (feeds the downstream frame counter enable) and flags malformed lines and frames.
module vid_frame_tracker
    import vid_frame_tracker_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    input  logic             s_tready,
    input  logic             s_tuser,
    input  logic             s_tlast,
    output logic             frame_done_out,
    output logic             frame_bad_out,
    output logic             line_err_out,
    output logic             sof_err_out,
    output logic [CNT_W-1:0] pix_cnt_out,
    output logic [CNT_W-1:0] line_cnt_out
);

    localparam logic [CNT_W-1:0] H_CNT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_CNT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic [CNT_W-1:0] r_pix;
    logic [CNT_W-1:0] r_line;
    logic             r_bad;
    logic             r_frame_done;
    logic             r_frame_bad;
    logic             r_line_err;
    logic             r_sof_err;

    logic             w_beat;
    logic             w_active;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_line_base;
    logic [CNT_W-1:0] w_line_inc;
    logic             w_bad_base;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_pix_nxt;
    logic [CNT_W-1:0] w_line_nxt;
    logic             w_bad_nxt;
    logic             w_frame_done;
    logic             w_frame_bad;
    logic             w_line_err;
    logic             w_sof_err;

    // Next-state decode: SOF handling first, then end-of-line on the same beat.
    always_comb begin
        w_beat       = s_tvalid & s_tready;
        w_active     = 1'b0;
        w_cnt        = r_pix;
        w_line_base  = r_line;
        w_bad_base   = r_bad;
        w_line_inc   = r_line;
        w_state_nxt  = r_state;
        w_pix_nxt    = r_pix;
        w_line_nxt   = r_line;
        w_bad_nxt    = r_bad;
        w_frame_done = 1'b0;
        w_frame_bad  = 1'b0;
        w_line_err   = 1'b0;
        w_sof_err    = 1'b0;

        if (w_beat && s_tuser) begin
            w_active    = 1'b1;
            w_sof_err   = (r_state == IN_FRAME);
            w_cnt       = CNT_ONE;
            w_line_base = '0;
            w_bad_base  = 1'b0;
        end else if (w_beat && (r_state == IN_FRAME)) begin
            w_active = 1'b1;
            w_cnt    = (r_pix == CNT_MAX) ? CNT_MAX : (r_pix + CNT_ONE);
        end else begin
            w_active = 1'b0;
        end

        if (w_active && s_tlast) begin
            w_line_err = (w_cnt != H_CNT);
            w_bad_nxt  = w_bad_base | w_line_err;
            w_line_inc = w_line_base + CNT_ONE;
            w_pix_nxt  = '0;
            if (w_line_inc == V_CNT) begin
                w_frame_done = 1'b1;
                w_frame_bad  = w_bad_base | w_line_err;
                w_line_nxt   = '0;
                w_state_nxt  = WAIT_SOF;
            end else begin
                w_line_nxt  = w_line_inc;
                w_state_nxt = IN_FRAME;
            end
        end else if (w_active) begin
            w_pix_nxt   = w_cnt;
            w_line_nxt  = w_line_base;
            w_bad_nxt   = w_bad_base;
            w_state_nxt = IN_FRAME;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, counters and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= WAIT_SOF;
            r_pix        <= '0;
            r_line       <= '0;
            r_bad        <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_bad  <= 1'b0;
            r_line_err   <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pix        <= w_pix_nxt;
            r_line       <= w_line_nxt;
            r_bad        <= w_bad_nxt;
            r_frame_done <= w_frame_done;
            r_frame_bad  <= w_frame_bad;
            r_line_err   <= w_line_err;
            r_sof_err    <= w_sof_err;
        end
    end

    assign frame_done_out = r_frame_done;
    assign frame_bad_out  = r_frame_bad;
    assign line_err_out   = r_line_err;
    assign sof_err_out    = r_sof_err;
    assign pix_cnt_out    = r_pix;
    assign line_cnt_out   = r_line;

endmodule : vid_frame_tracker
